// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage constants, state encoding and PC helpers.
package mips_pkg;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] PC_INCR    = 32'd4;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_instr_mem.sv
// instr_mem: word-addressed instruction ROM with combinational read.
module instr_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] word_addr,
    output logic [31:0]   rdata
);

    logic [31:0] memory [DEPTH];

    assign rdata = memory[word_addr];

endmodule

// File: rtl/if_fetch_unit_pc_reg.sv
// pc_reg: program counter register with asynchronous active-low reset.
module pc_reg #(
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_d,
    output logic [31:0] pc_q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= PC_RESET;
        else        pc_q <= pc_d;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage with PC, instruction ROM and IF/ID register.
// Optional performance counters are enabled with IF_PERF_CNT_EN.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] PC_RESET   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_halted
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    localparam int AW = $clog2(IMEM_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, pc_plus4;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc4_q, id_pc4_d;

    pc_reg #(.PC_RESET(PC_RESET)) pc_inst (
        .clk   (clk),
        .reset (reset),
        .pc_d  (pc_d),
        .pc_q  (pc_q)
    );

    instr_mem #(.DEPTH(IMEM_DEPTH)) imem_inst (
        .word_addr (pc_q[AW+1:2]),
        .rdata     (if_instr)
    );

    assign pc_plus4 = pc_q + PC_INCR;

    // Priority: halted > stall > redirect (flush) > HALT fetch > sequential.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;
        if (state_q == HALTED) begin
            id_instr_d = NOP_INSTR;
            id_pc4_d   = '0;
        end else if (!stall) begin
            if (redirect) begin
                pc_d       = align_word(redirect_pc);
                id_instr_d = NOP_INSTR;
                id_pc4_d   = '0;
            end else begin
                id_instr_d = if_instr;
                id_pc4_d   = pc_plus4;
                state_d    = (if_instr == HALT_INSTR) ? HALTED : FETCH;
                pc_d       = (if_instr == HALT_INSTR) ? pc_q : pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            id_instr_q <= NOP_INSTR;
            id_pc4_q   <= '0;
        end else begin
            state_q    <= state_d;
            id_instr_q <= id_instr_d;
            id_pc4_q   <= id_pc4_d;
        end
    end

    assign if_pc        = pc_q;
    assign id_instr     = id_instr_q;
    assign id_pc_plus4  = id_pc4_q;
    assign fetch_halted = (state_q == HALTED);

`ifdef IF_PERF_CNT_EN
    logic        fetch_inc, bubble_inc;
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    assign fetch_inc  = (state_q == FETCH) && !stall && !redirect && (if_instr != NOP_INSTR);
    assign bubble_inc = (state_q == HALTED) || (!stall && redirect);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_q + {31'd0, fetch_inc};
            bubble_cnt_q <= bubble_cnt_q + {31'd0, bubble_inc};
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

endmodule
